// File: rtl/alu_iter_exec.sv
// Execute-stage ALU: single-cycle add/sub/logic/pass-B, plus an iterative
// one-bit-per-cycle shifter for rotates and logical shifts, behind valid/ready.
module alu_iter_exec #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic             inv_a,
  input  logic             inv_b,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             ovf
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_ROL = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_ROR = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} stateT;

  stateT            state, nextState;
  logic [3:0]       opReg;
  logic [3:0]       countReg;
  logic [WIDTH-1:0] workReg;
  logic [WIDTH-1:0] aCond, bCond;
  logic [WIDTH:0]   sumFull;
  logic [WIDTH-1:0] immResult;
  logic             immCout, immOvf;
  logic             isShift, accept, needsLoop;
  logic [WIDTH-1:0] stepped;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && (state == IDLE);
  assign isShift   = (alu_op[3:2] == 2'b01);
  assign needsLoop = isShift && (op_b[3:0] != 4'd0);

  assign aCond   = inv_a ? ~op_a : op_a;
  assign bCond   = inv_b ? ~op_b : op_b;
  // inv_a doubles as carry-in so that ~A + B + 1 forms B - A
  assign sumFull = {1'b0, aCond} + {1'b0, bCond} + {{WIDTH{1'b0}}, inv_a};

  always_comb begin
    immResult = bCond;
    immCout   = 1'b0;
    immOvf    = 1'b0;
    case (alu_op)
      OP_ADD, OP_SUB: begin
        immResult = sumFull[WIDTH-1:0];
        immCout   = sumFull[WIDTH];
        immOvf    = (aCond[WIDTH-1] == bCond[WIDTH-1]) &&
                    (sumFull[WIDTH-1] != aCond[WIDTH-1]);
      end
      OP_XOR: immResult = aCond ^ bCond;
      OP_AND: immResult = aCond & bCond;
      OP_ROL, OP_SLL, OP_ROR, OP_SRL: immResult = aCond;
      default: immResult = bCond;
    endcase
  end

  always_comb begin
    stepped = workReg;
    case (opReg)
      OP_ROL: stepped = {workReg[WIDTH-2:0], workReg[WIDTH-1]};
      OP_SLL: stepped = {workReg[WIDTH-2:0], 1'b0};
      OP_ROR: stepped = {workReg[0], workReg[WIDTH-1:1]};
      OP_SRL: stepped = {1'b0, workReg[WIDTH-1:1]};
      default: stepped = workReg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (accept) nextState = needsLoop ? SHIFT : DONE;
      SHIFT: if (countReg == 4'd1) nextState = DONE;
      DONE:  if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Result registers only change when entering DONE, so they hold while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opReg    <= 4'd0;
      countReg <= 4'd0;
      workReg  <= '0;
      result   <= '0;
      zero     <= 1'b0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opReg    <= alu_op;
            countReg <= op_b[3:0];
            workReg  <= aCond;
            if (!needsLoop) begin
              result <= immResult;
              zero   <= (immResult == '0);
              cout   <= immCout;
              ovf    <= immOvf;
            end
          end
        end
        SHIFT: begin
          workReg  <= stepped;
          countReg <= countReg - 4'd1;
          if (countReg == 4'd1) begin
            result <= stepped;
            zero   <= (stepped == '0);
            cout   <= 1'b0;
            ovf    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter_exec.sv
// Self-checking bench for alu_iter_exec: directed vector table, handshake and
// reset corner sequences, then randomized ops against a behavioural model.
module tb_alu_iter_exec;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic        inv_a;
  logic        inv_b;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero;
  logic        cout;
  logic        ovf;

  int checks;
  int failures;

  alu_iter_exec #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .inv_a(inv_a), .inv_b(inv_b),
    .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        ia;
    logic        ib;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] expRes;
    logic        expZ;
    logic        expC;
    logic        expV;
    int          expLat;
  } vecT;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Reference model straight from the operation definitions, using wide integers
  function automatic void modelAlu(input logic [3:0] op, input logic ia, input logic ib,
                                   input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] res, output logic z,
                                   output logic c, output logic v, output int lat);
    int unsigned ap, bp, s, n;
    ap  = ia ? (~a & 16'hFFFF) : a;
    bp  = ib ? (~b & 16'hFFFF) : b;
    n   = b & 4'hF;
    c   = 1'b0;
    v   = 1'b0;
    lat = 1;
    case (op)
      4'd0, 4'd1: begin
        s   = ap + bp + (ia ? 1 : 0);
        res = s[15:0];
        c   = s[16];
        v   = (ap[15] == bp[15]) && (s[15] != ap[15]);
      end
      4'd2: res = 16'(ap ^ bp);
      4'd3: res = 16'(ap & bp);
      4'd4: res = 16'((ap << n) | (ap >> (16 - n)));
      4'd5: res = 16'(ap << n);
      4'd6: res = 16'((ap >> n) | (ap << (16 - n)));
      4'd7: res = 16'(ap >> n);
      default: res = bp[15:0];
    endcase
    if (op >= 4'd4 && op <= 4'd7) lat = n + 1;
    z = (res == 16'h0000);
  endfunction

  // Presents one op, waits for out_valid and reports latency/busy samples
  task automatic applyStimulus(input logic [3:0] op, input logic ia, input logic ib,
                               input logic [15:0] a, input logic [15:0] b,
                               output int lat, output int busy);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
    alu_op = op; inv_a = ia; inv_b = ib; op_a = a; op_b = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat  = 1;
    busy = 0;
    while (lat < 40) begin
      if (!in_ready) busy++;
      if (out_valid) break;
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) checkOutput("out_valid_timeout", 0, 1);
  endtask

  task automatic releaseOut(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({name, "_idle_ready"}, in_ready, 1);
    checkOutput({name, "_idle_valid"}, out_valid, 0);
  endtask

  vecT vecs[$];

  initial begin
    int lat, busy, hold, cnt;
    logic [15:0] mRes, held;
    logic mZ, mC, mV;
    int mLat;
    logic [3:0] rop;

    checks = 0; failures = 0;
    clk = 0; rst = 1; in_valid = 0; out_ready = 0;
    alu_op = 0; inv_a = 0; inv_b = 0; op_a = 0; op_b = 0;

    vecs.push_back('{4'd0, 0, 0, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 1, 1});
    vecs.push_back('{4'd1, 1, 0, 16'h0005, 16'h0005, 16'h0000, 1, 1, 0, 1});
    vecs.push_back('{4'd1, 1, 0, 16'h0003, 16'h000A, 16'h0007, 0, 1, 0, 1});
    vecs.push_back('{4'd6, 0, 0, 16'h0001, 16'h0004, 16'h1000, 0, 0, 0, 5});
    vecs.push_back('{4'd7, 0, 0, 16'h8000, 16'h000F, 16'h0001, 0, 0, 0, 16});
    vecs.push_back('{4'd3, 0, 1, 16'hFF0F, 16'h0F0F, 16'hF000, 0, 0, 0, 1});
    vecs.push_back('{4'd5, 0, 0, 16'h1234, 16'h0010, 16'h1234, 0, 0, 0, 1});
    vecs.push_back('{4'd2, 0, 0, 16'hAAAA, 16'h5555, 16'hFFFF, 0, 0, 0, 1});
    vecs.push_back('{4'd9, 0, 1, 16'h1234, 16'h00FF, 16'hFF00, 0, 0, 0, 1});
    vecs.push_back('{4'd4, 0, 0, 16'h8001, 16'h0001, 16'h0003, 0, 0, 0, 2});
    vecs.push_back('{4'd0, 0, 0, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 1});
    vecs.push_back('{4'd6, 1, 0, 16'h0F0F, 16'h0000, 16'hF0F0, 0, 0, 0, 1});
    vecs.push_back('{4'd7, 0, 1, 16'h0100, 16'h0002, 16'h0040, 0, 0, 0, 3});

    #12;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_flags", {zero, cout, ovf}, 0);
    rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].ia, vecs[i].ib, vecs[i].a, vecs[i].b, lat, busy);
      checkOutput($sformatf("vec%0d_result", i), result, vecs[i].expRes);
      checkOutput($sformatf("vec%0d_zero", i), zero, vecs[i].expZ);
      checkOutput($sformatf("vec%0d_cout", i), cout, vecs[i].expC);
      checkOutput($sformatf("vec%0d_ovf", i), ovf, vecs[i].expV);
      checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].expLat);
      checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].expLat);
      releaseOut($sformatf("vec%0d", i));
    end

    // Backpressure: result held while a competing in_valid is ignored
    applyStimulus(4'd3, 0, 1, 16'hFF0F, 16'h0F0F, lat, busy);
    alu_op = 4'd0; inv_a = 0; inv_b = 0; op_a = 16'h0001; op_b = 16'h0001;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("bp%0d_result", i), result, 16'hF000);
      checkOutput($sformatf("bp%0d_valid", i), out_valid, 1);
      checkOutput($sformatf("bp%0d_in_ready", i), in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp_release_in_ready", in_ready, 1);
    checkOutput("bp_release_valid", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("bp_new_valid", out_valid, 1);
    checkOutput("bp_new_result", result, 16'h0002);
    releaseOut("bp_new");

    // Asynchronous reset in the middle of a 12-step rotate
    alu_op = 4'd4; inv_a = 0; inv_b = 0; op_a = 16'h0001; op_b = 16'h000C;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_result", result, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    @(posedge clk); #2;
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    checkOutput("midrst_stale_valid", cnt, 0);
    checkOutput("midrst_ready_after", in_ready, 1);

    // Randomized ops with random output backpressure
    for (int i = 0; i < 200; i++) begin
      logic [15:0] ra, rb;
      logic ria, rib;
      rop = 4'($urandom_range(0, 15));
      ria = 1'($urandom);
      rib = 1'($urandom);
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if ((i % 8) == 0) ra = 16'h0000;
      modelAlu(rop, ria, rib, ra, rb, mRes, mZ, mC, mV, mLat);
      applyStimulus(rop, ria, rib, ra, rb, lat, busy);
      checkOutput($sformatf("rnd%0d_result", i), result, mRes);
      checkOutput($sformatf("rnd%0d_flags", i), {zero, cout, ovf}, {mZ, mC, mV});
      checkOutput($sformatf("rnd%0d_latency", i), lat, mLat);
      held = result;
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        checkOutput($sformatf("rnd%0d_hold", i), {out_valid, result}, {1'b1, held});
      end
      releaseOut($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
